// File: rtl/aftab_aau_sequencer_pkg.sv
// Shared definitions for the AAU issue sequencer: funct3 codes, FSM states and
// the RISC-V divide special-case constants.
package aftab_aau_sequencer_pkg;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_DONE
    } state_t;

    localparam logic [31:0] MOST_NEG = 32'h8000_0000;
    localparam logic [31:0] ALL_ONES = '1;

endpackage

// File: rtl/aftab_aau_sequencer_if.sv
// Request, AAU and result signals of the sequencer; master is the sequencer,
// slave is the requester/AAU/consumer side.
interface aftab_aau_sequencer_if #(
    parameter int size = 32
);
    logic            reqValid;
    logic            reqReady;
    logic [2:0]      op;
    logic [size-1:0] rs1;
    logic [size-1:0] rs2;
    logic [size-1:0] A;
    logic [size-1:0] B;
    logic            multAAU;
    logic            divideAAU;
    logic            signedSigned;
    logic            signedUnsigned;
    logic            unsignedUnsigned;
    logic [size-1:0] H;
    logic [size-1:0] L;
    logic            completeAAU;
    logic            dividedByZeroFlag;
    logic            resValid;
    logic            resReady;
    logic [size-1:0] result;
    logic            divZero;
    logic            timeoutErr;

    modport master (
        input  reqValid, op, rs1, rs2, H, L, completeAAU, dividedByZeroFlag, resReady,
        output reqReady, A, B, multAAU, divideAAU, signedSigned, signedUnsigned,
               unsignedUnsigned, resValid, result, divZero, timeoutErr
    );

    modport slave (
        output reqValid, op, rs1, rs2, H, L, completeAAU, dividedByZeroFlag, resReady,
        input  reqReady, A, B, multAAU, divideAAU, signedSigned, signedUnsigned,
               unsignedUnsigned, resValid, result, divZero, timeoutErr
    );

endinterface

// File: rtl/aftab_aau_op_decode.sv
// Combinational funct3 decode: divide class, AAU mode line and which AAU
// output half (H or L) carries the architectural result.
module aftab_aau_op_decode
    import aftab_aau_sequencer_pkg::*;
(
    input  logic [2:0] op_i,
    output logic       isDiv_o,
    output logic       signedSigned_o,
    output logic       signedUnsigned_o,
    output logic       unsignedUnsigned_o,
    output logic       selectHigh_o
);

    always_comb begin
        isDiv_o            = 1'b0;
        signedSigned_o     = 1'b0;
        signedUnsigned_o   = 1'b0;
        unsignedUnsigned_o = 1'b0;
        selectHigh_o       = 1'b0;
        unique case (op_i)
            OP_MUL:    signedSigned_o = 1'b1;
            OP_MULH:   begin signedSigned_o = 1'b1;     selectHigh_o = 1'b1; end
            OP_MULHSU: begin signedUnsigned_o = 1'b1;   selectHigh_o = 1'b1; end
            OP_MULHU:  begin unsignedUnsigned_o = 1'b1; selectHigh_o = 1'b1; end
            OP_DIV:    begin isDiv_o = 1'b1; signedSigned_o = 1'b1;     selectHigh_o = 1'b1; end
            OP_DIVU:   begin isDiv_o = 1'b1; unsignedUnsigned_o = 1'b1; selectHigh_o = 1'b1; end
            OP_REM:    begin isDiv_o = 1'b1; signedSigned_o = 1'b1;     end
            OP_REMU:   begin isDiv_o = 1'b1; unsignedUnsigned_o = 1'b1; end
            default:   ;
        endcase
    end

endmodule

// File: rtl/aftab_aau_sequencer.sv
// Issues one M-extension op to the AAU, waits for the completion edge and
// returns the selected result; divide-by-zero and overflow resolve locally.
module aftab_aau_sequencer
    import aftab_aau_sequencer_pkg::*;
#(
    parameter int size          = 32,
    parameter int timeoutCycles = 200
) (
    input  logic                  clk,
    input  logic                  rst,
    aftab_aau_sequencer_if.master bus
);

    localparam int CW = $clog2(timeoutCycles + 1);
    localparam logic [CW-1:0]   LastCount = CW'(timeoutCycles - 1);
    localparam logic [size-1:0] MostNeg   = size'(MOST_NEG);
    localparam logic [size-1:0] AllOnes   = size'(ALL_ONES);

    state_t          state_q, state_d;
    logic [size-1:0] a_q, a_d, b_q, b_d;
    logic            ss_q, ss_d, su_q, su_d, uu_q, uu_d;
    logic            isDiv_q, isDiv_d, selHigh_q, selHigh_d;
    logic [size-1:0] result_q, result_d;
    logic            divZero_q, divZero_d, timeout_q, timeout_d;
    logic [CW-1:0]   count_q, count_d;
    logic            prevComplete_q;

    logic decIsDiv, decSS, decSU, decUU, decSelHigh;

    aftab_aau_op_decode u_decode (
        .op_i               (bus.op),
        .isDiv_o            (decIsDiv),
        .signedSigned_o     (decSS),
        .signedUnsigned_o   (decSU),
        .unsignedUnsigned_o (decUU),
        .selectHigh_o       (decSelHigh)
    );

    // The AAU flag is informational only; the local rs2 check decides divZero.
    logic unusedDbz;
    assign unusedDbz = bus.dividedByZeroFlag;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            ss_q      <= 1'b0;
            su_q      <= 1'b0;
            uu_q      <= 1'b0;
            isDiv_q   <= 1'b0;
            selHigh_q <= 1'b0;
            result_q  <= '0;
            divZero_q <= 1'b0;
            timeout_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            ss_q      <= ss_d;
            su_q      <= su_d;
            uu_q      <= uu_d;
            isDiv_q   <= isDiv_d;
            selHigh_q <= selHigh_d;
            result_q  <= result_d;
            divZero_q <= divZero_d;
            timeout_q <= timeout_d;
            count_q   <= count_d;
        end
    end

    // Tracks completeAAU every cycle (LAUNCH included), so a level still high
    // from the previous op is seen as old when WAIT begins, never as an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) prevComplete_q <= 1'b0;
        else      prevComplete_q <= bus.completeAAU;
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        ss_d      = ss_q;
        su_d      = su_q;
        uu_d      = uu_q;
        isDiv_d   = isDiv_q;
        selHigh_d = selHigh_q;
        result_d  = result_q;
        divZero_d = divZero_q;
        timeout_d = timeout_q;
        count_d   = count_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.reqValid) begin
                    a_d       = bus.rs1;
                    b_d       = bus.rs2;
                    ss_d      = decSS;
                    su_d      = decSU;
                    uu_d      = decUU;
                    isDiv_d   = decIsDiv;
                    selHigh_d = decSelHigh;
                    if (decIsDiv && bus.rs2 == '0) begin
                        result_d  = decSelHigh ? AllOnes : bus.rs1;
                        divZero_d = 1'b1;
                        state_d   = ST_DONE;
                    end else if (decIsDiv && decSS && bus.rs1 == MostNeg && bus.rs2 == AllOnes) begin
                        result_d = decSelHigh ? MostNeg : '0;
                        state_d  = ST_DONE;
                    end else begin
                        state_d = ST_LAUNCH;
                    end
                end
            end
            ST_LAUNCH: begin
                count_d = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.completeAAU && !prevComplete_q) begin
                    result_d = selHigh_q ? bus.H : bus.L;
                    state_d  = ST_DONE;
                end else if (count_q == LastCount) begin
                    result_d  = '0;
                    timeout_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (bus.resReady) begin
                    divZero_d = 1'b0;
                    timeout_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.reqReady         = (state_q == ST_IDLE);
    assign bus.resValid         = (state_q == ST_DONE);
    assign bus.multAAU          = (state_q == ST_LAUNCH) && !isDiv_q;
    assign bus.divideAAU        = (state_q == ST_LAUNCH) && isDiv_q;
    assign bus.A                = a_q;
    assign bus.B                = b_q;
    assign bus.signedSigned     = ss_q;
    assign bus.signedUnsigned   = su_q;
    assign bus.unsignedUnsigned = uu_q;
    assign bus.result           = result_q;
    assign bus.divZero          = divZero_q;
    assign bus.timeoutErr       = timeout_q;

endmodule

// File: tb/tb_aftab_aau_sequencer.sv
// Directed bench for aftab_aau_sequencer with a simple AAU latency model.
module tb_aftab_aau_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    aftab_aau_sequencer_if #(.size(32)) bus ();

    aftab_aau_sequencer #(.size(32), .timeoutCycles(200)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int passes = 0;

    // AAU model: drops completeAAU mDrop cycles after a start, raises it with
    // H/L mLat cycles after the start, or never when mNever is set.
    logic        mComplete = 1'b0;
    logic [31:0] hOut = '0, lOut = '0;
    logic        mBusy = 1'b0;
    int          mCnt = 0;
    logic [31:0] mH = '0, mL = '0;
    int          mLat = 34, mDrop = 0;
    logic        mNever = 1'b0;

    assign bus.completeAAU       = mComplete;
    assign bus.H                 = hOut;
    assign bus.L                 = lOut;
    assign bus.dividedByZeroFlag = 1'b0;

    always @(posedge clk) begin
        if (bus.multAAU || bus.divideAAU) begin
            mBusy <= 1'b1;
            mCnt  <= 1;
            if (mDrop == 0) mComplete <= 1'b0;
        end else if (mBusy) begin
            if (mCnt == mDrop) mComplete <= 1'b0;
            if (mCnt == mLat && !mNever) begin
                mComplete <= 1'b1;
                hOut      <= mH;
                lOut      <= mL;
                mBusy     <= 1'b0;
            end
            mCnt <= mCnt + 1;
        end
    end

    int   multCount = 0, divCount = 0;
    logic prevStart = 1'b0, b2bSeen = 1'b0, bothSeen = 1'b0;
    always @(negedge clk) begin
        if (bus.multAAU === 1'b1) multCount <= multCount + 1;
        if (bus.divideAAU === 1'b1) divCount <= divCount + 1;
        if ((bus.multAAU || bus.divideAAU) && prevStart) b2bSeen <= 1'b1;
        if (bus.multAAU && bus.divideAAU) bothSeen <= 1'b1;
        prevStart <= bus.multAAU || bus.divideAAU;
    end

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a, b, h, l, res;
        logic [2:0]  mode;   // {signedSigned, signedUnsigned, unsignedUnsigned}
        logic        dz;
    } vec_t;

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output bit ok);
        int n = 0;
        @(negedge clk);
        bus.op = o; bus.rs1 = a; bus.rs2 = b; bus.reqValid = 1'b1;
        while (bus.reqReady !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        ok = (bus.reqReady === 1'b1);
        @(negedge clk);
        bus.reqValid = 1'b0;
    endtask

    task automatic wait_res(input int maxc, output int cyc);
        cyc = 0;
        while (bus.resValid !== 1'b1 && cyc < maxc) begin @(negedge clk); cyc++; end
    endtask

    task automatic finish_res();
        bus.resReady = 1'b1;
        @(negedge clk);
        bus.resReady = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.reqReady, bus.resValid, bus.multAAU, bus.divideAAU} !== 4'b1000)
            $display("FAIL reset_ctrl got %b want 1000", {bus.reqReady, bus.resValid, bus.multAAU, bus.divideAAU});
        else passes++;
        checks++;
        if ({bus.A, bus.B, bus.result} !== '0 ||
            {bus.signedSigned, bus.signedUnsigned, bus.unsignedUnsigned, bus.divZero, bus.timeoutErr} !== 5'b0)
            $display("FAIL reset_data got A=%h B=%h res=%h", bus.A, bus.B, bus.result);
        else passes++;
        rst = 1'b1;
    endtask

    task automatic test_launched_ops();
        vec_t v[6];
        v[0] = '{"mul",    3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 32'hFFFFFFEB, 3'b100, 1'b0};
        v[1] = '{"mulhu",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFE, 3'b001, 1'b0};
        v[2] = '{"mulhsu", 3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 3'b010, 1'b0};
        v[3] = '{"div",    3'd4, 32'hFFFFFFEC, 32'd6,        32'hFFFFFFFD, 32'hFFFFFFFE, 32'hFFFFFFFD, 3'b100, 1'b0};
        v[4] = '{"rem",    3'd6, 32'hFFFFFFEC, 32'd6,        32'hFFFFFFFD, 32'hFFFFFFFE, 32'hFFFFFFFE, 3'b100, 1'b0};
        v[5] = '{"divu",   3'd5, 32'd100,      32'd7,        32'd14,       32'd2,        32'd14,       3'b001, 1'b0};
        for (int i = 0; i < 6; i++) begin
            bit ok; int cyc, m0, d0; logic [1:0] startExp;
            mH = v[i].h; mL = v[i].l; mLat = 34; mDrop = 0; mNever = 1'b0;
            m0 = multCount; d0 = divCount;
            startExp = (v[i].op < 3'd4) ? 2'b10 : 2'b01;
            issue(v[i].op, v[i].a, v[i].b, ok);
            checks++;
            if (!ok || {bus.multAAU, bus.divideAAU} !== startExp || bus.A !== v[i].a || bus.B !== v[i].b)
                $display("FAIL %s_launch got start=%b A=%h B=%h want start=%b A=%h B=%h",
                         v[i].name, {bus.multAAU, bus.divideAAU}, bus.A, bus.B, startExp, v[i].a, v[i].b);
            else passes++;
            wait_res(100, cyc);
            checks++;
            if (cyc !== mLat + 2)
                $display("FAIL %s_latency got %0d want %0d", v[i].name, cyc, mLat + 2);
            else passes++;
            checks++;
            if (bus.result !== v[i].res || bus.divZero !== 1'b0 || bus.timeoutErr !== 1'b0)
                $display("FAIL %s_result got %h dz=%b to=%b want %h", v[i].name, bus.result,
                         bus.divZero, bus.timeoutErr, v[i].res);
            else passes++;
            checks++;
            if ({bus.signedSigned, bus.signedUnsigned, bus.unsignedUnsigned} !== v[i].mode)
                $display("FAIL %s_mode got %b want %b", v[i].name,
                         {bus.signedSigned, bus.signedUnsigned, bus.unsignedUnsigned}, v[i].mode);
            else passes++;
            finish_res();
            checks++;
            if ((multCount - m0) !== int'(startExp[1]) || (divCount - d0) !== int'(startExp[0]))
                $display("FAIL %s_pulses got mult=%0d div=%0d want %b", v[i].name,
                         multCount - m0, divCount - d0, startExp);
            else passes++;
        end
    endtask

    task automatic test_short_circuit();
        vec_t v[6];
        v[0] = '{"divu_zero", 3'd5, 32'h1234,     32'h0,        '0, '0, 32'hFFFFFFFF, 3'b001, 1'b1};
        v[1] = '{"remu_zero", 3'd7, 32'h1234,     32'h0,        '0, '0, 32'h00001234, 3'b001, 1'b1};
        v[2] = '{"div_zero",  3'd4, 32'd5,        32'h0,        '0, '0, 32'hFFFFFFFF, 3'b100, 1'b1};
        v[3] = '{"rem_zero",  3'd6, 32'h80000000, 32'h0,        '0, '0, 32'h80000000, 3'b100, 1'b1};
        v[4] = '{"div_ovf",   3'd4, 32'h80000000, 32'hFFFFFFFF, '0, '0, 32'h80000000, 3'b100, 1'b0};
        v[5] = '{"rem_ovf",   3'd6, 32'h80000000, 32'hFFFFFFFF, '0, '0, 32'h00000000, 3'b100, 1'b0};
        for (int i = 0; i < 6; i++) begin
            bit ok; int m0, d0;
            m0 = multCount; d0 = divCount;
            issue(v[i].op, v[i].a, v[i].b, ok);
            checks++;
            if (!ok || bus.resValid !== 1'b1 || bus.reqReady !== 1'b0)
                $display("FAIL %s_timing got resValid=%b reqReady=%b want 1 0", v[i].name,
                         bus.resValid, bus.reqReady);
            else passes++;
            checks++;
            if (bus.result !== v[i].res || bus.divZero !== v[i].dz || bus.timeoutErr !== 1'b0)
                $display("FAIL %s_result got %h dz=%b want %h dz=%b", v[i].name, bus.result,
                         bus.divZero, v[i].res, v[i].dz);
            else passes++;
            finish_res();
            checks++;
            if ((multCount - m0) !== 0 || (divCount - d0) !== 0 || bus.divZero !== 1'b0)
                $display("FAIL %s_nostart got mult=%0d div=%0d dz=%b want 0 0 0", v[i].name,
                         multCount - m0, divCount - d0, bus.divZero);
            else passes++;
        end
    endtask

    task automatic test_stale_complete();
        bit ok; int cyc;
        // completeAAU is still high from the last launched op
        checks++;
        if (bus.completeAAU !== 1'b1) $display("FAIL stale_precond got %b want 1", bus.completeAAU);
        else passes++;
        mH = 32'h0000_0000; mL = 32'h0000_0042; mLat = 10; mDrop = 5;
        issue(3'd0, 32'd6, 32'd11, ok);
        wait_res(100, cyc);
        checks++;
        if (cyc !== 12) $display("FAIL stale_latency got %0d want 12", cyc);
        else passes++;
        checks++;
        if (bus.result !== 32'h42) $display("FAIL stale_result got %h want 00000042", bus.result);
        else passes++;
        finish_res();
        mDrop = 0;
    endtask

    task automatic test_hold_result();
        bit ok, stable; int cyc;
        mH = 32'h0; mL = 32'h0000_0063; mLat = 3; stable = 1'b1;
        issue(3'd0, 32'd9, 32'd11, ok);
        wait_res(50, cyc);
        repeat (10) begin
            @(negedge clk);
            if (bus.resValid !== 1'b1 || bus.result !== 32'h63 || bus.divZero !== 1'b0) stable = 1'b0;
        end
        checks++;
        if (!stable) $display("FAIL hold_stable got resValid=%b result=%h want 1 00000063", bus.resValid, bus.result);
        else passes++;
        finish_res();
        checks++;
        if ({bus.reqReady, bus.resValid} !== 2'b10)
            $display("FAIL hold_exit got %b want 10", {bus.reqReady, bus.resValid});
        else passes++;
    endtask

    task automatic test_timeout();
        bit ok; int cyc;
        mNever = 1'b1;
        issue(3'd1, 32'd3, 32'd4, ok);
        wait_res(300, cyc);
        checks++;
        if (cyc !== 201) $display("FAIL timeout_latency got %0d want 201", cyc);
        else passes++;
        checks++;
        if (bus.result !== 32'h0 || bus.timeoutErr !== 1'b1 || bus.divZero !== 1'b0)
            $display("FAIL timeout_result got %h to=%b want 00000000 to=1", bus.result, bus.timeoutErr);
        else passes++;
        finish_res();
        checks++;
        if (bus.timeoutErr !== 1'b0) $display("FAIL timeout_clear got %b want 0", bus.timeoutErr);
        else passes++;
    endtask

    task automatic test_reset_in_wait();
        bit ok, quiet;
        mNever = 1'b1; quiet = 1'b1;
        issue(3'd0, 32'd2, 32'd3, ok);
        repeat (4) @(negedge clk);
        checks++;
        if ({bus.reqReady, bus.resValid} !== 2'b00)
            $display("FAIL rstwait_pre got %b want 00", {bus.reqReady, bus.resValid});
        else passes++;
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.reqReady, bus.resValid, bus.multAAU, bus.divideAAU} !== 4'b1000 || bus.A !== 32'h0)
            $display("FAIL rstwait_abort got %b A=%h want 1000 A=0",
                     {bus.reqReady, bus.resValid, bus.multAAU, bus.divideAAU}, bus.A);
        else passes++;
        @(negedge clk);
        rst = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (bus.resValid !== 1'b0 || bus.reqReady !== 1'b1) quiet = 1'b0;
        end
        checks++;
        if (!quiet) $display("FAIL rstwait_quiet got resValid=%b want 0", bus.resValid);
        else passes++;
        mNever = 1'b0;
    endtask

    task automatic test_back_to_back();
        bit ok; int cyc;
        mH = 32'h0; mL = 32'h0000_0050; mLat = 4;
        issue(3'd5, 32'h1234, 32'h0, ok);
        bus.op = 3'd0; bus.rs1 = 32'd8; bus.rs2 = 32'd10;
        bus.reqValid = 1'b1; bus.resReady = 1'b1;
        checks++;
        if ({bus.resValid, bus.reqReady} !== 2'b10)
            $display("FAIL b2b_done got resValid,reqReady=%b want 10", {bus.resValid, bus.reqReady});
        else passes++;
        @(negedge clk);
        bus.resReady = 1'b0;
        checks++;
        if ({bus.reqReady, bus.multAAU, bus.resValid} !== 3'b100)
            $display("FAIL b2b_idle got %b want 100", {bus.reqReady, bus.multAAU, bus.resValid});
        else passes++;
        @(negedge clk);
        bus.reqValid = 1'b0;
        checks++;
        if (bus.multAAU !== 1'b1 || bus.signedSigned !== 1'b1)
            $display("FAIL b2b_launch got mult=%b ss=%b want 1 1", bus.multAAU, bus.signedSigned);
        else passes++;
        wait_res(50, cyc);
        checks++;
        if (bus.result !== 32'h50 || bus.divZero !== 1'b0)
            $display("FAIL b2b_result got %h dz=%b want 00000050 dz=0", bus.result, bus.divZero);
        else passes++;
        finish_res();
        checks++;
        if (b2bSeen !== 1'b0 || bothSeen !== 1'b0)
            $display("FAIL start_pulses got b2b=%b both=%b want 0 0", b2bSeen, bothSeen);
        else passes++;
    endtask

    initial begin
        bus.reqValid = 1'b0; bus.resReady = 1'b0;
        bus.op = '0; bus.rs1 = '0; bus.rs2 = '0;
        test_reset();
        test_launched_ops();
        test_short_circuit();
        test_stale_complete();
        test_hold_result();
        test_timeout();
        test_reset_in_wait();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no finish want finish before 500000");
        $display("%0d/%0d checks passed", passes, checks + 1);
        $fatal(1);
    end

endmodule
